graph_adjacency_server: RTL and testbench

//   Responder side of the path-counting engine's adjacency fetch interface.

---
 rtl/gas_pkg.sv | 21 ++
 rtl/graph_csr_tables.sv | 47 ++++
 rtl/graph_adjacency_server.sv | 135 +++++++++++++
 tb/tb_graph_adjacency_server.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gas_pkg.sv
// gas_pkg: shared FSM state encoding, config selector codes and default widths
// for the graph adjacency server.
package gas_pkg;

    localparam int NIW_DEF = 10;
    localparam int CW_DEF  = 4;
    localparam int EAW_DEF = 12;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_END    = 2'd1,
        S_LOOKUP = 2'd2,
        S_STREAM = 2'd3
    } state_e;

    localparam logic [1:0] CFG_SEL_NODE  = 2'b00;
    localparam logic [1:0] CFG_SEL_EDGE  = 2'b01;
    localparam logic [1:0] CFG_SEL_PART0 = 2'b10;
    localparam logic [1:0] CFG_SEL_PART1 = 2'b11;

endpackage

// File: rtl/graph_csr_tables.sv
// graph_csr_tables: CSR node/edge tables plus start/end pairs, written over the
// config port while idle, with combinational node and edge read ports.
module graph_csr_tables
    import gas_pkg::*;
#(
    parameter int NIW = NIW_DEF,
    parameter int CW  = CW_DEF,
    parameter int EAW = EAW_DEF
) (
    input  logic              clk_i,
    input  logic              cfg_we_i,
    input  logic [1:0]        cfg_sel_i,
    input  logic [EAW-1:0]    cfg_addr_i,
    input  logic [EAW+CW-1:0] cfg_wdata_i,
    input  logic              busy_i,
    input  logic              part_sel_i,
    input  logic [NIW-1:0]    node_rd_idx_i,
    input  logic [EAW-1:0]    edge_rd_addr_i,
    output logic [EAW-1:0]    node_base_o,
    output logic [CW-1:0]     node_deg_o,
    output logic [NIW-1:0]    edge_data_o,
    output logic [NIW-1:0]    start_idx_o,
    output logic [NIW-1:0]    end_idx_o
);

    logic [EAW+CW-1:0] node_tbl_q [2**NIW];
    logic [NIW-1:0]    edge_tbl_q [2**EAW];
    // indexed {part, is_end}
    logic [NIW-1:0]    ends_q     [4];

    always_ff @(posedge clk_i) begin
        if (cfg_we_i && !busy_i) begin
            if (cfg_sel_i == CFG_SEL_NODE)
                node_tbl_q[cfg_addr_i[NIW-1:0]] <= cfg_wdata_i;
            else if (cfg_sel_i == CFG_SEL_EDGE)
                edge_tbl_q[cfg_addr_i] <= cfg_wdata_i[NIW-1:0];
            else
                ends_q[{cfg_sel_i[0], cfg_addr_i[0]}] <= cfg_wdata_i[NIW-1:0];
        end
    end

    assign {node_base_o, node_deg_o} = node_tbl_q[node_rd_idx_i];
    assign edge_data_o = edge_tbl_q[edge_rd_addr_i];
    assign start_idx_o = ends_q[{part_sel_i, 1'b0}];
    assign end_idx_o   = ends_q[{part_sel_i, 1'b1}];

endmodule

// File: rtl/graph_adjacency_server.sv
// graph_adjacency_server: presents start node, end node, then streams each requested
// node's successor list with a countdown, one entry per cycle, gated by start_run.
module graph_adjacency_server
    import gas_pkg::*;
#(
    parameter int PARAM_NODE_IDX_WIDTH  = NIW_DEF,
    parameter int PARAM_COUNTER_WIDTH   = CW_DEF,
    parameter int PARAM_EDGE_ADDR_WIDTH = EAW_DEF
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_ni,
    input  logic                                                 cfg_we_i,
    input  logic [1:0]                                           cfg_sel_i,
    input  logic [PARAM_EDGE_ADDR_WIDTH-1:0]                     cfg_addr_i,
    input  logic [PARAM_EDGE_ADDR_WIDTH+PARAM_COUNTER_WIDTH-1:0] cfg_wdata_i,
    input  logic                                                 part_sel_i,
    input  logic                                                 start_run_i,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]                      node_idx_i,
    input  logic                                                 rd_next_node_i,
    input  logic                                                 done_i,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]                      next_node_idx_o,
    output logic [PARAM_COUNTER_WIDTH-1:0]                       next_node_counter_o,
    output logic                                                 busy_o,
    output logic                                                 err_zero_degree_o
);

    localparam int NIW = PARAM_NODE_IDX_WIDTH;
    localparam int CW  = PARAM_COUNTER_WIDTH;
    localparam int EAW = PARAM_EDGE_ADDR_WIDTH;

    state_e         state_q, state_d;
    logic [NIW-1:0] idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [EAW-1:0] ptr_q, ptr_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;

    logic [EAW-1:0] node_base;
    logic [CW-1:0]  node_deg;
    logic [NIW-1:0] edge_data, start_idx, end_idx;
    logic [EAW-1:0] edge_rd_addr;

    // The lookup cycle reads the list head directly so the first successor costs no bubble.
    assign edge_rd_addr = (state_q == S_LOOKUP) ? node_base : ptr_q;

    graph_csr_tables #(.NIW(NIW), .CW(CW), .EAW(EAW)) u_tables (
        .clk_i          (clk_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_sel_i      (cfg_sel_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_wdata_i    (cfg_wdata_i),
        .busy_i         (busy_q),
        .part_sel_i     (part_sel_i),
        .node_rd_idx_i  (node_idx_i),
        .edge_rd_addr_i (edge_rd_addr),
        .node_base_o    (node_base),
        .node_deg_o     (node_deg),
        .edge_data_o    (edge_data),
        .start_idx_o    (start_idx),
        .end_idx_o      (end_idx)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        err_d   = err_q;
        if (start_run_i) begin
            if (done_i) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        idx_d   = start_idx;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_END;
                    end
                    S_END: begin
                        idx_d   = end_idx;
                        cnt_d   = '0;
                        state_d = S_LOOKUP;
                    end
                    S_LOOKUP: begin
                        cnt_d = '0;
                        if (rd_next_node_i) begin
                            if (node_deg == '0) begin
                                err_d = 1'b1;
                            end else begin
                                idx_d   = edge_data;
                                cnt_d   = node_deg;
                                ptr_d   = node_base + EAW'(1);
                                state_d = S_STREAM;
                            end
                        end
                    end
                    default: begin
                        idx_d   = (cnt_q > CW'(1)) ? edge_data : idx_q;
                        cnt_d   = (cnt_q > CW'(1)) ? cnt_q - CW'(1) : '0;
                        ptr_d   = (cnt_q > CW'(1)) ? ptr_q + EAW'(1) : ptr_q;
                        state_d = (cnt_q > CW'(1)) ? S_STREAM : S_LOOKUP;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign next_node_idx_o     = idx_q;
    assign next_node_counter_o = cnt_q;
    assign busy_o              = busy_q;
    assign err_zero_degree_o   = err_q;

endmodule

// File: tb/tb_graph_adjacency_server.sv
// tb_graph_adjacency_server: random graph loads and runs; a list-level reference model
// queues the expected output per clock and a negedge monitor compares.
module tb_graph_adjacency_server;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [11:0] cfg_addr;
    logic [15:0] cfg_wdata;
    logic        part_sel;
    logic        start_run;
    logic [9:0]  node_idx;
    logic        rd_next_node;
    logic        done;
    logic [9:0]  next_node_idx;
    logic [3:0]  next_node_counter;
    logic        busy;
    logic        err_zero_degree;

    always #5 clk = ~clk;

    graph_adjacency_server dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .cfg_we_i            (cfg_we),
        .cfg_sel_i           (cfg_sel),
        .cfg_addr_i          (cfg_addr),
        .cfg_wdata_i         (cfg_wdata),
        .part_sel_i          (part_sel),
        .start_run_i         (start_run),
        .node_idx_i          (node_idx),
        .rd_next_node_i      (rd_next_node),
        .done_i              (done),
        .next_node_idx_o     (next_node_idx),
        .next_node_counter_o (next_node_counter),
        .busy_o              (busy),
        .err_zero_degree_o   (err_zero_degree)
    );

    typedef struct {
        int         c;
        logic [9:0] idx;
        logic [3:0] cnt;
        logic       busy;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   cyc_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   nodes_q[$];

    logic [11:0] nbase [1024];
    logic [3:0]  ndeg  [1024];
    logic [9:0]  emem  [4096];
    logic [9:0]  st [2];
    logic [9:0]  en [2];
    logic [9:0]  m_idx = '0;
    logic [3:0]  m_cnt = '0;
    logic        m_busy = 1'b0;
    logic        m_err = 1'b0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0 && q[0].c <= cyc_n) begin
            e = q.pop_front();
            checks++;
            if (e.c != cyc_n || next_node_idx !== e.idx || next_node_counter !== e.cnt ||
                busy !== e.busy || err_zero_degree !== e.err) begin
                errors++;
                $display("FAIL out cyc=%0d/%0d idx=%0d want %0d cnt=%0d want %0d busy=%0b want %0b err=%0b want %0b",
                         cyc_n, e.c, next_node_idx, e.idx, next_node_counter, e.cnt,
                         busy, e.busy, err_zero_degree, e.err);
            end
        end
    end

    task automatic drive(input logic sr, input logic dn, input logic [9:0] ni, input logic rd,
                         input logic we, input logic [1:0] sel, input logic [11:0] a,
                         input logic [15:0] wd);
        start_run = sr; done = dn; node_idx = ni; rd_next_node = rd;
        cfg_we = we; cfg_sel = sel; cfg_addr = a; cfg_wdata = wd;
    endtask

    task automatic tick();
        q.push_back('{cyc_n + 1, m_idx, m_cnt, m_busy, m_err});
        @(negedge clk);
    endtask

    task automatic mcfg(input logic we, input logic [1:0] sel, input logic [11:0] a,
                        input logic [15:0] wd);
        if (we && !m_busy) begin
            case (sel)
                2'd0: begin nbase[a[9:0]] = wd[15:4]; ndeg[a[9:0]] = wd[3:0]; end
                2'd1: emem[a] = wd[9:0];
                2'd2: if (a[0]) en[0] = wd[9:0]; else st[0] = wd[9:0];
                default: if (a[0]) en[1] = wd[9:0]; else st[1] = wd[9:0];
            endcase
        end
    endtask

    task automatic cfg(input logic sr, input logic [1:0] sel, input logic [11:0] a,
                       input logic [15:0] wd);
        drive(sr, 0, 0, 0, 1, sel, a, wd);
        mcfg(1, sel, a, wd);
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) begin drive(0, 0, 0, 0, 0, 0, 0, 0); tick(); end
    endtask

    task automatic wait_lookup();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        m_idx = '0; m_cnt = '0; m_busy = 1'b0; m_err = 1'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic start(input logic p, input logic we, input logic [1:0] sel,
                         input logic [11:0] a, input logic [15:0] wd);
        part_sel = p;
        drive(1, 0, 0, 0, we, sel, a, wd);
        m_idx = st[p]; m_cnt = '0;
        mcfg(we, sel, a, wd);
        m_busy = 1'b1;
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        m_idx = en[p];
        tick();
    endtask

    // fz < 0: random 0..2 frozen cycles before each later entry; fz >= 0: exactly fz before entry 1
    task automatic request(input int n, input int fz);
        logic [11:0] b;
        logic [3:0]  d;
        b = nbase[n];
        d = ndeg[n];
        if (d == 0) begin
            drive(1, 0, 10'(n), 1, 0, 0, 0, 0);
            m_cnt = '0; m_err = 1'b1;
            tick();
        end else begin
            for (int k = 0; k < int'(d); k++) begin
                if (k > 0) repeat (fz < 0 ? int'($urandom_range(0, 2)) : (k == 1 ? fz : 0)) begin
                    drive(0, 0, 10'(n), 0, 0, 0, 0, 0);
                    tick();
                end
                drive(1, 0, 10'(n), k == 0, 0, 0, 0, 0);
                m_idx = emem[b + 12'(k)];
                m_cnt = d - 4'(k);
                tick();
            end
            drive(1, 0, 10'(n), 0, 0, 0, 0, 0);
            m_cnt = '0;
            tick();
        end
    endtask

    task automatic finish_run();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        m_cnt = '0; m_busy = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] b;
        logic [3:0]  d;
        int          n;
        part_sel = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        do_reset();
        do_reset();
        cfg(0, 2'd2, 12'd0, 16'd3);
        cfg(0, 2'd2, 12'd1, 16'd9);
        cfg(0, 2'd3, 12'd0, 16'd5);
        cfg(0, 2'd3, 12'd1, 16'd9);
        cfg(0, 2'd0, 12'd3, {12'd0, 4'd3});
        cfg(0, 2'd1, 12'd0, 16'd4);
        cfg(0, 2'd1, 12'd1, 16'd6);
        cfg(0, 2'd1, 12'd2, 16'd9);
        cfg(0, 2'd0, 12'd4, {12'd3, 4'd1});
        cfg(0, 2'd1, 12'd3, 16'd9);
        cfg(0, 2'd0, 12'd7, {12'd50, 4'd0});
        cfg(0, 2'd0, 12'd8, {12'd4095, 4'd2});
        cfg(0, 2'd1, 12'd4095, 16'd123);
        start(1, 0, 0, 0, 0);
        request(3, 0);
        request(4, 0);
        request(3, 3);
        wait_lookup();
        cfg(1, 2'd0, 12'd3, {12'd100, 4'd2});
        request(8, 0);
        request(7, 0);
        request(3, 0);
        finish_run();
        idle(2);
        start(0, 1, 2'd2, 12'd0, 16'd7);
        request(4, -1);
        finish_run();
        idle(1);
        start(0, 0, 0, 0, 0);
        drive(1, 0, 10'd3, 1, 0, 0, 0, 0);
        m_idx = emem[nbase[3]]; m_cnt = ndeg[3];
        tick();
        drive(1, 0, 10'd3, 0, 0, 0, 0, 0);
        m_idx = emem[nbase[3] + 12'd1]; m_cnt = ndeg[3] - 4'd1;
        tick();
        do_reset();
        idle(1);
        nodes_q = '{3, 4, 7, 8};
        for (int i = 0; i < 20; i++) begin
            n = 100 + 37 * i;
            b = 12'($urandom_range(0, 4095));
            d = 4'($urandom_range(0, 15));
            cfg(0, 2'd0, 12'(n), {b, d});
            for (int k = 0; k < int'(d); k++) cfg(0, 2'd1, b + 12'(k), 16'($urandom % 1024));
            nodes_q.push_back(n);
        end
        repeat (6) begin
            start(1'($urandom % 2), 0, 0, 0, 0);
            repeat (8) begin
                repeat ($urandom_range(0, 2)) wait_lookup();
                if ($urandom % 4 == 0)
                    cfg(1, 2'($urandom % 2), 12'($urandom % 4096), 16'($urandom));
                request(nodes_q[$urandom % nodes_q.size()], -1);
            end
            finish_run();
            idle($urandom_range(1, 3));
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
